// File: rtl/gmii_rx_deframer_if.sv
// Output-side byte stream of the GMII receive deframer: srdy/drdy handshake
// carrying one frame byte plus its SOP/EOP code per transfer.
interface gmii_rx_deframer_if;
  logic       p_srdy;
  logic       p_drdy;
  logic [7:0] p_data;
  logic [1:0] p_code;

  modport master (
    output p_srdy,
    output p_data,
    output p_code,
    input  p_drdy
  );

  modport slave (
    input  p_srdy,
    input  p_data,
    input  p_code,
    output p_drdy
  );
endinterface

// File: rtl/gmii_rx_deframer.sv
// GMII receive deframer: strips preamble/SFD/FCS, checks CRC-32 and length, and queues
// frame bytes tagged SOP/EOP-good/EOP-bad. Define GMII_RX_STATS_EN to add good/bad frame counters.
module gmii_rx_deframer #(
  parameter int FIFO_DEPTH = 16,
  parameter int MIN_LEN    = 64,
  parameter int MAX_LEN    = 1518
) (
  input  logic               rx_clk,
  input  logic               reset_n,
  input  logic               rx_dv,
  input  logic [7:0]         rxd,
  gmii_rx_deframer_if.master p_if
`ifdef GMII_RX_STATS_EN
  ,
  output logic [15:0]        good_cnt,
  output logic [15:0]        bad_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  localparam logic [1:0]  CODE_DATA   = 2'b00;
  localparam logic [1:0]  CODE_SOP    = 2'b01;
  localparam logic [1:0]  CODE_GOOD   = 2'b10;
  localparam logic [1:0]  CODE_BAD    = 2'b11;
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    DROP = 2'd3
  } state_t;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) begin
        c = {1'b0, c[31:1]} ^ CRC_POLY;
      end else begin
        c = {1'b0, c[31:1]};
      end
    end
    return c;
  endfunction

  state_t          state_q, state_d;
  logic [4:0][7:0] dl_q;
  logic [10:0]     len_q;
  logic [31:0]     crc_q;
  logic            dv_prev_q;
  logic            abort_q, abort_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            srdy_q, srdy_d;
  logic [9:0]      head_q, head_d;
  logic [9:0]      mem_q [FIFO_DEPTH];

  logic            start_s;
  logic            shift_s;
  logic            frm_wr_s;
  logic [1:0]      frm_code_s;
  logic            short_s;
  logic            good_s;
  logic            rd_s;
  logic            full_s;
  logic            room_s;
  logic            ovf_s;
  logic            mark_s;
  logic            we_s;
  logic [9:0]      wr_ent_s;

  assign good_s = (crc_q == CRC_RESIDUE) && (len_q >= 11'(MIN_LEN)) && (len_q <= 11'(MAX_LEN));

  // A write into a full FIFO still lands if the head is being read on the same edge.
  assign rd_s     = srdy_q && p_if.p_drdy;
  assign full_s   = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}};
  assign room_s   = !full_s || rd_s;
  assign ovf_s    = frm_wr_s && !room_s;
  assign mark_s   = abort_q && !frm_wr_s && room_s;
  assign we_s     = (frm_wr_s && room_s) || mark_s;
  assign wr_ent_s = mark_s ? {CODE_BAD, 8'h00} : {frm_code_s, dl_q[4]};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_s};
  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, we_s};

  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // dv_prev_q resets high so a frame already on the wire at reset release is dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (rx_dv) begin
          if ((rxd == 8'h55) && !dv_prev_q && !abort_q) state_d = PRE;
          else                                           state_d = DROP;
        end else begin
          state_d = IDLE;
        end
      end
      PRE: begin
        if (!rx_dv)              state_d = IDLE;
        else if (rxd == 8'h55)   state_d = PRE;
        else if (rxd == 8'hD5)   state_d = DATA;
        else                     state_d = DROP;
      end
      DATA: begin
        if (!rx_dv)     state_d = IDLE;
        else if (ovf_s) state_d = DROP;
        else            state_d = DATA;
      end
      DROP: begin
        if (!rx_dv) state_d = IDLE;
        else        state_d = DROP;
      end
      default: state_d = IDLE;
    endcase
  end

  // dl_q[4] is the byte just past the 4-byte FCS window; it is released only once the
  // next byte proves it is not the last data byte, or as EOP when rx_dv falls.
  always_comb begin
    start_s    = 1'b0;
    shift_s    = 1'b0;
    frm_wr_s   = 1'b0;
    frm_code_s = CODE_DATA;
    short_s    = 1'b0;
    case (state_q)
      PRE: start_s = rx_dv && (rxd == 8'hD5);
      DATA: begin
        if (rx_dv) begin
          shift_s = 1'b1;
          if (len_q >= 11'd5) begin
            frm_wr_s   = 1'b1;
            frm_code_s = (len_q == 11'd5) ? CODE_SOP : CODE_DATA;
          end else begin
            frm_wr_s = 1'b0;
          end
        end else if (len_q >= 11'd5) begin
          frm_wr_s   = 1'b1;
          frm_code_s = good_s ? CODE_GOOD : CODE_BAD;
        end else begin
          short_s = 1'b1;
        end
      end
      default: start_s = 1'b0;
    endcase
  end

  always_comb begin
    abort_d = abort_q;
    if (ovf_s) begin
      abort_d = 1'b1;
    end else if (mark_s) begin
      abort_d = 1'b0;
    end else begin
      abort_d = abort_q;
    end
  end

  // Registered FIFO head: a write into the slot becoming head bypasses the memory.
  always_comb begin
    srdy_d = 1'b0;
    head_d = head_q;
    if (rd_ptr_d != wr_ptr_d) begin
      srdy_d = 1'b1;
      if (we_s && (rd_ptr_d == wr_ptr_q)) begin
        head_d = wr_ent_s;
      end else begin
        head_d = mem_q[rd_ptr_d[AW-1:0]];
      end
    end else begin
      srdy_d = 1'b0;
      head_d = head_q;
    end
  end

  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      dl_q      <= '0;
      len_q     <= 11'd0;
      crc_q     <= CRC_INIT;
      dv_prev_q <= 1'b1;
      abort_q   <= 1'b0;
      wr_ptr_q  <= {PW{1'b0}};
      rd_ptr_q  <= {PW{1'b0}};
      srdy_q    <= 1'b0;
      head_q    <= 10'd0;
    end else begin
      dv_prev_q <= rx_dv;
      abort_q   <= abort_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      srdy_q    <= srdy_d;
      head_q    <= head_d;
      if (start_s) begin
        dl_q  <= '0;
        len_q <= 11'd0;
        crc_q <= CRC_INIT;
      end else if (shift_s) begin
        dl_q  <= {dl_q[3:0], rxd};
        crc_q <= crc32_byte(crc_q, rxd);
        if (len_q != 11'h7FF) len_q <= len_q + 11'd1;
      end
    end
  end

  always_ff @(posedge rx_clk) begin
    if (we_s) mem_q[wr_ptr_q[AW-1:0]] <= wr_ent_s;
  end

  assign p_if.p_srdy = srdy_q;
  assign p_if.p_data = head_q[7:0];
  assign p_if.p_code = head_q[9:8];

`ifdef GMII_RX_STATS_EN
  logic [15:0] good_q;
  logic [15:0] bad_q;

  // Frames that write nothing (length <= 4) still count as bad.
  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      good_q <= 16'd0;
      bad_q  <= 16'd0;
    end else begin
      if (we_s && (wr_ent_s[9:8] == CODE_GOOD) && (good_q != 16'hFFFF)) good_q <= good_q + 16'd1;
      if (((we_s && (wr_ent_s[9:8] == CODE_BAD)) || short_s) && (bad_q != 16'hFFFF)) bad_q <= bad_q + 16'd1;
    end
  end

  assign good_cnt = good_q;
  assign bad_cnt  = bad_q;
`endif

endmodule

// File: tb/tb_gmii_rx_deframer.sv
// Scoreboard bench for gmii_rx_deframer: frames are built with a locally computed FCS,
// expected FIFO entries are queued at drive time and popped on each output transfer.
module tb_gmii_rx_deframer;
  localparam int DEPTH = 16;

  logic       rx_clk = 1'b0;
  logic       reset_n;
  logic       rx_dv;
  logic [7:0] rxd;

  gmii_rx_deframer_if pif ();

`ifdef GMII_RX_STATS_EN
  logic [15:0] good_cnt;
  logic [15:0] bad_cnt;
`endif

  gmii_rx_deframer #(.FIFO_DEPTH(DEPTH), .MIN_LEN(64), .MAX_LEN(1518)) dut (
    .rx_clk  (rx_clk),
    .reset_n (reset_n),
    .rx_dv   (rx_dv),
    .rxd     (rxd),
    .p_if    (pif)
`ifdef GMII_RX_STATS_EN
    ,
    .good_cnt(good_cnt),
    .bad_cnt (bad_cnt)
`endif
  );

  always #4 rx_clk = ~rx_clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          pop_cnt = 0;
  int          sop_lim = 0;
  logic        lat_arm = 1'b0;
  logic        lat_done = 1'b0;
  logic        hold_v = 1'b0;
  logic [10:0] hold_val = 11'd0;
  logic [9:0]  exp_q [$];
  logic [7:0]  frm [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  always @(posedge rx_clk) cyc <= cyc + 1;

  // Output monitor: stability while stalled, and scoreboard pop on every transfer.
  always @(negedge rx_clk) begin
    if (!reset_n) begin
      hold_v <= 1'b0;
    end else begin
      if (hold_v) check_eq("hold", {21'd0, pif.p_srdy, pif.p_code, pif.p_data}, {21'd0, hold_val});
      hold_v   <= pif.p_srdy && !pif.p_drdy;
      hold_val <= {pif.p_srdy, pif.p_code, pif.p_data};
      if (pif.p_srdy && pif.p_drdy) begin
        pop_cnt <= pop_cnt + 1;
        if (exp_q.size() == 0) begin
          check_eq("extra_entry", 32'(exp_q.size()), 32'd1);
        end else begin
          check_eq("entry", {22'd0, pif.p_code, pif.p_data}, {22'd0, exp_q.pop_front()});
          if (lat_arm && !lat_done && (pif.p_code == 2'b01)) begin
            check_eq("latency", 32'(cyc <= sop_lim), 32'd1);
            lat_done <= 1'b1;
          end
        end
      end
    end
  end

  task automatic drive(input logic dv, input logic [7:0] d);
    @(posedge rx_clk);
    #1;
    rx_dv = dv;
    rxd   = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
  endtask

  task automatic build(input int len);
    logic [31:0] c;
    logic [7:0]  b;
    frm.delete();
    c = 32'hFFFFFFFF;
    for (int i = 0; i < len - 4; i++) begin
      b = 8'($urandom);
      frm.push_back(b);
      c = crc_upd(c, b);
    end
    c = ~c;
    frm.push_back(c[7:0]);
    frm.push_back(c[15:8]);
    frm.push_back(c[23:16]);
    frm.push_back(c[31:24]);
  endtask

  task automatic expect_frame(input logic good);
    int n;
    logic [1:0] code;
    n = frm.size();
    for (int i = 0; i < n - 4; i++) begin
      if (i == n - 5)  code = good ? 2'b10 : 2'b11;
      else if (i == 0) code = 2'b01;
      else             code = 2'b00;
      exp_q.push_back({code, frm[i]});
    end
  endtask

  task automatic send(input logic arm_lat);
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    for (int i = 0; i < frm.size(); i++) begin
      drive(1'b1, frm[i]);
      if (i == 0 && arm_lat) begin
        sop_lim = cyc + 7;
        lat_arm = 1'b1;
      end
    end
    idle(12);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge rx_clk);
    check_eq(tag, 32'(exp_q.size()), 32'd0);
    idle(4);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    reset_n    = 1'b0;
    rx_dv      = 1'b0;
    rxd        = 8'h00;
    pif.p_drdy = 1'b1;
    repeat (3) @(posedge rx_clk);
    #1;
    check_eq("rst_srdy", 32'(pif.p_srdy), 32'd0);
    check_eq("rst_data", 32'(pif.p_data), 32'd0);
    check_eq("rst_code", 32'(pif.p_code), 32'd0);
    reset_n = 1'b1;
    idle(5);

    // Good 64-byte frame, with SOP latency check.
    build(64);
    expect_frame(1'b1);
    send(1'b1);
    wait_drain("drain_good64");

    // Corrupted byte 20.
    build(64);
    frm[20] = frm[20] ^ 8'hFF;
    expect_frame(1'b0);
    send(1'b0);
    wait_drain("drain_crcbad");

    // Runt with valid FCS, then a 3-byte frame.
    build(60);
    expect_frame(1'b0);
    send(1'b0);
    wait_drain("drain_runt60");
    frm.delete();
    for (int i = 0; i < 3; i++) frm.push_back(8'($urandom));
    send(1'b0);
    idle(20);
    wait_drain("drain_short3");

    // Broken preamble, then a clean frame.
    drive(1'b1, 8'h55);
    drive(1'b1, 8'h55);
    drive(1'b1, 8'h12);
    for (int i = 0; i < 64; i++) drive(1'b1, 8'($urandom));
    idle(12);
    build(64);
    expect_frame(1'b1);
    send(1'b0);
    wait_drain("drain_after_badpre");
`ifdef GMII_RX_STATS_EN
    check_eq("good_cnt_a", 32'(good_cnt), 32'd2);
    check_eq("bad_cnt_a", 32'(bad_cnt), 32'd3);
`endif

    // Overflow: consumer stalled for a 100-byte frame, then a frame while abort is pending.
    @(posedge rx_clk);
    #1;
    pif.p_drdy = 1'b0;
    build(100);
    for (int i = 0; i < DEPTH; i++) exp_q.push_back({(i == 0) ? 2'b01 : 2'b00, frm[i]});
    exp_q.push_back({2'b11, 8'h00});
    send(1'b0);
    build(64);
    send(1'b0);
    idle(10);
    check_eq("full_held", 32'(exp_q.size()), 32'(DEPTH + 1));
    pif.p_drdy = 1'b1;
    wait_drain("drain_overflow");
    idle(20);
`ifdef GMII_RX_STATS_EN
    check_eq("good_cnt_b", 32'(good_cnt), 32'd2);
    check_eq("bad_cnt_b", 32'(bad_cnt), 32'd4);
`endif

    // Reset pulse at data byte 30, remainder of the frame must be ignored.
    build(64);
    for (int i = 0; i < 25; i++) exp_q.push_back({(i == 0) ? 2'b01 : 2'b00, frm[i]});
    base = pop_cnt;
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    for (int i = 0; i < 30; i++) drive(1'b1, frm[i]);
    @(posedge rx_clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_eq("midrst_srdy", 32'(pif.p_srdy), 32'd0);
    check_eq("midrst_code", 32'(pif.p_code), 32'd0);
    check_eq("midrst_prefix", 32'((pop_cnt - base) >= 20), 32'd1);
    exp_q.delete();
    repeat (2) @(posedge rx_clk);
    #1;
    reset_n = 1'b1;
    for (int i = 30; i < 64; i++) drive(1'b1, frm[i]);
    idle(12);
    build(64);
    expect_frame(1'b1);
    send(1'b0);
    wait_drain("drain_after_reset");
    idle(20);
`ifdef GMII_RX_STATS_EN
    check_eq("good_cnt_c", 32'(good_cnt), 32'd1);
    check_eq("bad_cnt_c", 32'(bad_cnt), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gmii_rx_deframer.md
GMII_RX_DEFRAMER -- requirements
Module: gmii_rx_deframer

Interface
- REQ-001: The block SHALL have one clock and an asynchronous, active-low reset, with ports named as the codebase does.
- REQ-002: Parameter FIFO_DEPTH, default 16, SHALL set the output FIFO entries; it SHALL be a power of 2 and at least 4.
- REQ-003: Parameter MIN_LEN, default 64, SHALL set the minimum good frame length in bytes, DA through FCS.
- REQ-004: Parameter MAX_LEN, default 1518, SHALL set the maximum good frame length in bytes, DA through FCS.
- REQ-005: Port rx_clk, input, 1 bit: the GMII receive clock; all logic SHALL run on its rising edge.
- REQ-006: Port reset_n, input, 1 bit: asynchronous, active-low reset.
- REQ-007: Port rx_dv, input, 1 bit: GMII data valid.
- REQ-008: Port rxd, input, 8 bits: GMII receive data.
- REQ-009: Port p_srdy, output, 1 bit: an output entry is valid.
- REQ-010: Port p_drdy, input, 1 bit: the consumer accepts the entry.
- REQ-011: Port p_data, output, 8 bits: frame byte.
- REQ-012: Port p_code, output, 2 bits: 00 data, 01 SOP (first byte), 10 EOP-good, 11 EOP-bad.

Function
- REQ-013: The state machine SHALL have states IDLE, PRE, DATA and DROP.
- REQ-014: IDLE: rx_dv=1 with rxd=0x55 SHALL go to PRE; rx_dv=1 with any other rxd SHALL go to DROP.
- REQ-015: PRE: 0x55 SHALL stay in PRE; 0xD5 (SFD) SHALL go to DATA; another byte SHALL go to DROP; rx_dv=0 SHALL go to IDLE.
- REQ-016: DROP: the block SHALL ignore input until rx_dv=0, then return to IDLE.
- REQ-017: DATA: every byte with rx_dv=1 SHALL enter a 4-byte delay line; the byte leaving the delay line SHALL be written to the FIFO, so the FCS is never output.
- REQ-018: DATA: rx_dv=0 SHALL end the frame and the block SHALL return to IDLE on the same edge.
- REQ-019: CRC-32 SHALL use reflected polynomial 0xEDB88320 with init 0xFFFFFFFF, computed over all bytes after the SFD, FCS included, with FCS received LSB first.
- REQ-020: A frame SHALL be good only if the residue equals 0xDEBB20E3 and MIN_LEN <= length <= MAX_LEN.
- REQ-021: The length counter SHALL be 11 bits and SHALL saturate at 2047.
- REQ-022: The first byte written for each frame SHALL carry SOP.
- REQ-023: The last data byte of a frame (the byte before the FCS) SHALL carry EOP-good or EOP-bad, written on the cycle after rx_dv falls.
- REQ-024: A frame with length <= 4 SHALL write nothing to the FIFO and SHALL count as bad.
- REQ-025: Latency: a byte sampled at edge N SHALL reach p_data by edge N+6 when the FIFO is empty and p_drdy=1.
- REQ-026: A transfer SHALL occur when p_srdy and p_drdy are both 1 on a rising edge.
- REQ-027: p_data and p_code SHALL remain stable while p_srdy=1 and p_drdy=0.
- REQ-028: On a simultaneous FIFO write and read when full, the read SHALL complete and the write SHALL be accepted in the same cycle.
- REQ-029: If the FIFO is full at a write, the byte SHALL be discarded and abort_pend set; the block SHALL drop the rest of the frame.
- REQ-030: While abort_pend is set, the block SHALL write one entry (data 0x00, code EOP-bad) at the first free slot, then clear abort_pend.
- REQ-031: A frame whose preamble begins while abort_pend is set SHALL be dropped whole.
- REQ-032: Pointers SHALL be log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH; full and empty SHALL be decoded from the MSB difference.

Reset
- REQ-033: While reset_n=0, the block SHALL hold state=IDLE, p_srdy=0, p_data=0x00, p_code=00, FIFO empty, delay line clear, abort_pend=0 and statistics 0.
- REQ-034: Reset asserted mid-frame SHALL discard the partial frame with no EOP emitted.
- REQ-035: After release, a frame already in progress SHALL be seen as DROP until rx_dv=0.

Configuration
- REQ-036: Macro GMII_RX_STATS_EN, when defined, SHALL add output ports good_cnt (16 bits) and bad_cnt (16 bits).
- REQ-037: good_cnt and bad_cnt SHALL increment once per EOP-good and once per EOP-bad or aborted/length<=4 frame respectively, and SHALL saturate at 0xFFFF.
- REQ-038: When GMII_RX_STATS_EN is undefined, those ports and counters SHALL be absent; all other behaviour SHALL be identical.

Verification
- REQ-039: 7x0x55, 0xD5, 64-byte frame with valid FCS, p_drdy=1 -> 60 entries: SOP on DA[0], EOP-good on byte 59, good_cnt=1.
- REQ-040: Same frame with byte 20 flipped -> 60 entries, last EOP-bad, bad_cnt=1.
- REQ-041: 60-byte frame with valid FCS -> 56 entries, EOP-bad; 3-byte frame -> no entries, bad_cnt+1.
- REQ-042: 0x55, 0x55, 0x12 then 64 bytes -> no output; next clean frame received normally.
- REQ-043: p_drdy=0 for an entire 100-byte frame, FIFO_DEPTH=16 -> 16 entries held, then one 0x00/EOP-bad after drain, rest dropped.
- REQ-044: reset_n pulsed low at data byte 30 -> p_srdy=0 immediately, no EOP; next frame good.
